// File: rtl/valve_pkg.sv
// Shared types and helpers for the valve actuator.
package valve_pkg;

    typedef enum logic [2:0] {
        StInit,
        StClosed,
        StOpening,
        StOpen,
        StClosing,
        StFault
    } state_e;

    localparam int unsigned ActW = 16;

    // Travel timer must hold values up to and including the timeout.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/req_debounce.sv
// Single-bit debounce filter: output follows input after it holds for DEBOUNCE cycles.
module req_debounce
    import valve_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (din != filt_q) begin
            // Counter would reach DEBOUNCE on this edge: accept and rearm.
            if (cnt_q == CntW'(DEBOUNCE - 1)) begin
                filt_d = din;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/valve_actuator.sv
// Motorised valve sequencer with limit-switch confirmation and travel timeout.
// Optional actuation counter enabled by VALVE_ACTUATOR_CYCLE_COUNT_EN.
module valve_actuator
    import valve_pkg::*;
#(
    parameter int unsigned DEBOUNCE       = 4,
    parameter int unsigned TRAVEL_TIMEOUT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic valve_req,
    input  logic lim_open,
    input  logic lim_closed,
    input  logic fault_clr,
    output logic motor_open,
    output logic motor_close,
    output logic valve_is_open,
    output logic fault
`ifdef VALVE_ACTUATOR_CYCLE_COUNT_EN
    ,
    output logic [ActW-1:0] actuations
`endif
);

    localparam int unsigned TimerW = timer_width(TRAVEL_TIMEOUT);

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              req_filt;
    logic              both_lim;
    logic              timeout;
    logic              travel;

    req_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_req_debounce (
        .clk (clk),
        .rst (rst),
        .din (valve_req),
        .dout(req_filt)
    );

    assign both_lim = lim_open & lim_closed;
    assign travel   = (state_q == StOpening) || (state_q == StClosing);
    // Timer reaches TRAVEL_TIMEOUT on this edge.
    assign timeout  = (timer_q == TimerW'(TRAVEL_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit: state_d = StClosing;
            StClosed: begin
                if (both_lim)      state_d = StFault;
                else if (req_filt) state_d = StOpening;
            end
            StOpening: begin
                if (both_lim)      state_d = StFault;
                else if (lim_open) state_d = StOpen;
                else if (timeout)  state_d = StFault;
            end
            StOpen: begin
                if (both_lim)       state_d = StFault;
                else if (!req_filt) state_d = StClosing;
            end
            StClosing: begin
                if (both_lim)        state_d = StFault;
                else if (lim_closed) state_d = StClosed;
                else if (timeout)    state_d = StFault;
            end
            StFault: begin
                if (fault_clr) state_d = StClosing;
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (travel && (state_d == state_q)) begin
            if (timer_q != TimerW'(TRAVEL_TIMEOUT)) begin
                timer_d = timer_q + TimerW'(1);
            end else begin
                timer_d = timer_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Outputs are forced low during reset so drives drop in the reset cycle itself.
    assign motor_open    = !rst && (state_q == StOpening);
    assign motor_close   = !rst && (state_q == StClosing);
    assign valve_is_open = !rst && (state_q == StOpen);
    assign fault         = !rst && (state_q == StFault);

`ifdef VALVE_ACTUATOR_CYCLE_COUNT_EN
    logic [ActW-1:0] act_q, act_d;

    always_comb begin
        act_d = act_q;
        if (((state_q == StOpening) && (state_d == StOpen)) ||
            ((state_q == StClosing) && (state_d == StClosed))) begin
            if (act_q != '1) act_d = act_q + ActW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) act_q <= '0;
        else     act_q <= act_d;
    end

    assign actuations = rst ? '0 : act_q;
`endif

endmodule

// File: tb/tb_valve_actuator.sv
// Directed bench for valve_actuator with an expected-output scoreboard.
module tb_valve_actuator;

    localparam logic [3:0] ExpOff = 4'b0000;
    localparam logic [3:0] ExpMo  = 4'b1000;
    localparam logic [3:0] ExpMc  = 4'b0100;
    localparam logic [3:0] ExpOp  = 4'b0010;
    localparam logic [3:0] ExpFl  = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valve_req = 1'b0;
    logic lim_open = 1'b0;
    logic lim_closed = 1'b0;
    logic fault_clr = 1'b0;
    logic motor_open, motor_close, valve_is_open, fault;
`ifdef VALVE_ACTUATOR_CYCLE_COUNT_EN
    logic [15:0] actuations;
`endif

    always #5 clk = ~clk;

    valve_actuator #(
        .DEBOUNCE      (4),
        .TRAVEL_TIMEOUT(20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valve_req    (valve_req),
        .lim_open     (lim_open),
        .lim_closed   (lim_closed),
        .fault_clr    (fault_clr),
        .motor_open   (motor_open),
        .motor_close  (motor_close),
        .valve_is_open(valve_is_open),
        .fault        (fault)
`ifdef VALVE_ACTUATOR_CYCLE_COUNT_EN
        ,
        .actuations   (actuations)
`endif
    );

    typedef struct {
        string       tag;
        logic [3:0]  outs;
        logic [15:0] act;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    string       phase = "reset";
    logic [3:0]  prev_exp = ExpOff;
    logic [15:0] act_exp = 16'd0;

    task automatic push_exp(input logic [3:0] outs);
        exp_t e;
        e.tag  = phase;
        e.outs = outs;
        e.act  = act_exp;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [3:0] obs;
        e   = sb.pop_front();
        obs = {motor_open, motor_close, valve_is_open, fault};
        tests++;
        assert (obs === e.outs) else begin
            fails++;
            $error("FAIL %s: {mo,mc,open,fault} got %b expected %b", e.tag, obs, e.outs);
        end
        tests++;
        assert ((motor_open & motor_close) === 1'b0) else begin
            fails++;
            $error("FAIL %s_excl: motor_open&motor_close got %b expected 0", e.tag,
                   motor_open & motor_close);
        end
`ifdef VALVE_ACTUATOR_CYCLE_COUNT_EN
        tests++;
        assert (actuations === e.act) else begin
            fails++;
            $error("FAIL %s_act: actuations got %0d expected %0d", e.tag, actuations, e.act);
        end
`endif
    endtask

    // Check outputs within the current cycle (combinational response).
    task automatic expect_now(input logic [3:0] outs);
        push_exp(outs);
        #1;
        compare();
    endtask

    // Advance one clock edge; outs is the expected Moore output after it.
    task automatic cyc(input logic [3:0] outs);
        if (((prev_exp == ExpMo) && (outs == ExpOp)) ||
            ((prev_exp == ExpMc) && (outs == ExpOff))) begin
            if (act_exp != 16'hFFFF) act_exp++;
        end
        prev_exp = outs;
        push_exp(outs);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic cycn(input logic [3:0] outs, input int n);
        for (int i = 0; i < n; i++) cyc(outs);
    endtask

    task automatic do_reset();
        phase    = "reset";
        rst      = 1'b1;
        act_exp  = 16'd0;
        prev_exp = ExpOff;
        expect_now(ExpOff);
        cycn(ExpOff, 2);
        rst   = 1'b0;
        phase = "init";
        expect_now(ExpOff);
    endtask

    initial begin
        do_reset();

        phase = "homing";
        cycn(ExpMc, 5);
        lim_closed = 1'b1;
        cyc(ExpOff);

        phase = "open";
        valve_req = 1'b1;
        cycn(ExpOff, 4);
        cyc(ExpMo);
        lim_closed = 1'b0;
        cycn(ExpMo, 7);
        lim_open = 1'b1;
        cycn(ExpOp, 2);

        phase = "close";
        valve_req = 1'b0;
        cycn(ExpOp, 4);
        cyc(ExpMc);
        lim_open = 1'b0;
        cycn(ExpMc, 2);
        lim_closed = 1'b1;
        cyc(ExpOff);

        phase = "glitch";
        valve_req = 1'b1;
        cycn(ExpOff, 3);
        valve_req = 1'b0;
        cycn(ExpOff, 5);

        phase = "timeout";
        valve_req = 1'b1;
        cycn(ExpOff, 4);
        cyc(ExpMo);
        lim_closed = 1'b0;
        cycn(ExpMo, 19);
        cyc(ExpFl);
        phase = "fault_hold";
        cycn(ExpFl, 2);
        phase = "fault_clr";
        fault_clr = 1'b1;
        cyc(ExpMc);
        fault_clr = 1'b0;
        lim_closed = 1'b1;
        cyc(ExpOff);
        phase = "reopen";
        cyc(ExpMo);
        lim_closed = 1'b0;
        lim_open = 1'b1;
        cyc(ExpOp);

        phase = "both_lim";
        lim_closed = 1'b1;
        cyc(ExpFl);
        valve_req = 1'b0;
        phase = "clr_both";
        fault_clr = 1'b1;
        cyc(ExpMc);
        fault_clr = 1'b0;
        cyc(ExpFl);
        phase = "clr_close";
        lim_open = 1'b0;
        fault_clr = 1'b1;
        cyc(ExpMc);
        fault_clr = 1'b0;
        cycn(ExpOff, 2);

        phase = "lim_vs_timeout";
        valve_req = 1'b1;
        cycn(ExpOff, 4);
        cyc(ExpMo);
        lim_closed = 1'b0;
        cycn(ExpMo, 19);
        lim_open = 1'b1;
        cycn(ExpOp, 2);

        phase = "close2";
        valve_req = 1'b0;
        cycn(ExpOp, 4);
        cyc(ExpMc);
        lim_open = 1'b0;
        lim_closed = 1'b1;
        cyc(ExpOff);

        phase = "mid_travel";
        valve_req = 1'b1;
        cycn(ExpOff, 4);
        cyc(ExpMo);
        lim_closed = 1'b0;
        cycn(ExpMo, 2);
        valve_req = 1'b0;
        do_reset();
        phase = "rehome";
        cyc(ExpMc);
        lim_closed = 1'b1;
        cycn(ExpOff, 2);

        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/valve_actuator.md
Name: valve_actuator

Overview:
- Downstream stage of the combinational flow-control decoder; consumes its single-bit `valve` request and drives a motorised valve.
- Debounces the request and sequences the motor open/close drives.
- Confirms travel against limit switches and flags a fault on travel timeout or contradictory limit switches.
- Single clock domain; sits between the decision logic and the pin-level actuator drivers.

Parameters:
- DEBOUNCE, 4: consecutive cycles `valve_req` must hold a new value before it is accepted (min 1).
- TRAVEL_TIMEOUT, 20: maximum cycles allowed in OPENING or CLOSING before FAULT (min 2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- valve_req  input  1  open request from the flow-control decoder (1 = open)
- lim_open  input  1  fully-open limit switch, already synchronised
- lim_closed  input  1  fully-closed limit switch, already synchronised
- fault_clr  input  1  single-cycle pulse; leaves FAULT
- motor_open  output  1  drive motor in the open direction
- motor_close  output  1  drive motor in the close direction
- valve_is_open  output  1  high only in OPEN
- fault  output  1  high only in FAULT

Behaviour:
- Reset: state = INIT, debounce counter = 0, filtered request = 0, travel timer = 0. While rst is high, all outputs are 0.
- All outputs are a Moore decode of the state register. motor_open and motor_close are never high together.
- Debounce:
  - A change of `valve_req` relative to the filtered request restarts the counter at 1.
  - The filtered request takes the new value on the edge where the counter reaches DEBOUNCE.
  - A glitch shorter than DEBOUNCE cycles is ignored.
- States:
  - INIT: outputs 0; goes to CLOSING unconditionally on the next edge. This is a safe homing close after every reset.
  - CLOSED: motors off. Goes to OPENING when the filtered request is 1.
  - OPENING: motor_open=1. Goes to OPEN when lim_open=1. Goes to FAULT when the timer reaches TRAVEL_TIMEOUT.
  - OPEN: motors off, valve_is_open=1. Goes to CLOSING when the filtered request is 0.
  - CLOSING: motor_close=1. Goes to CLOSED when lim_closed=1. Goes to FAULT when the timer reaches TRAVEL_TIMEOUT.
  - FAULT: motors off, fault=1. Goes to CLOSING on fault_clr. Ignores valve_req.
- Travel timer:
  - Cleared on entry to OPENING or CLOSING; increments every cycle in those states; held at 0 elsewhere.
  - Width is $clog2(TRAVEL_TIMEOUT+1); it never wraps.
- Priority, highest first:
  1. rst
  2. lim_open and lim_closed both 1 in any state other than INIT or FAULT → FAULT
  3. limit-reached
  4. timeout
  5. request-driven transitions
- A limit switch and timeout in the same cycle resolve as a limit hit (success).
- No mid-travel reversal: a request change during OPENING or CLOSING is held by the filter and acted on once the end state is reached.
- fault_clr outside FAULT is ignored. fault_clr together with both limits asserted re-enters FAULT on the following cycle.
- Reset mid-travel aborts travel immediately: the motor drives drop in the reset cycle and homing restarts via INIT.

Optional Feature:
- Macro: VALVE_ACTUATOR_CYCLE_COUNT_EN.
- Defined:
  - Adds output port `actuations` (16-bit), reset to 0.
  - Increments by 1 on every OPENING→OPEN and CLOSING→CLOSED transition, including the homing close after INIT.
  - Saturates at 0xFFFF.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Package `valve_pkg`:
  - state enum: INIT, CLOSED, OPENING, OPEN, CLOSING, FAULT.
  - a localparam helper for the timer width.
- One sub-module, `req_debounce`:
  - parameter DEBOUNCE.
  - ports clk, rst, din, dout.
  - instantiated once for valve_req.

Test Plan (DEBOUNCE=4, TRAVEL_TIMEOUT=20):
- Reset released, lim_closed asserted 5 cycles later → INIT for 1 cycle, motor_close=1 for 5 cycles, then CLOSED with all outputs 0.
- From CLOSED, valve_req=1 held; lim_open asserted 8 cycles after motor_open rises → motor_open rises 5 edges after valve_req rose, then OPEN with valve_is_open=1 and motors off.
- From CLOSED, valve_req pulsed high for 3 cycles → no state change; motor_open stays 0.
- From CLOSED, valve_req=1 with lim_open never asserted → motor_open high for exactly 20 cycles, then fault=1 and motors off; fault_clr pulse → CLOSING (motor_close=1).
- In OPEN, lim_open and lim_closed both forced to 1 → FAULT on the next edge.
- With VALVE_ACTUATOR_CYCLE_COUNT_EN defined: homing close plus 3 full open/close pairs → actuations = 7. Assert rst in mid-OPENING → actuations = 0 and motor_open = 0 in the reset cycle.
